// File: rtl/elink_rx_pkg.sv
// elink_rx_pkg: shared codes and FSM state type for the RX e-link packer.
package elink_rx_pkg;

  // Input e-link word codes (din[9:8])
  localparam logic [1:0] CODE_SOP   = 2'b10;
  localparam logic [1:0] CODE_EOP   = 2'b01;
  localparam logic [1:0] CODE_DATA  = 2'b00;
  localparam logic [1:0] CODE_COMMA = 2'b11;

  // Output FIFO word codes (dout[17:16])
  localparam logic [1:0] OCODE_SOP   = 2'b10;
  localparam logic [1:0] OCODE_DATA  = 2'b00;
  localparam logic [1:0] OCODE_EOP   = 2'b01;
  localparam logic [1:0] OCODE_LAST1 = 2'b11;

  // Framing state: outside a packet, at a byte-pair boundary, or holding one byte
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } rx_state_e;

  // Assemble an 18-bit FIFO word from a code and a 16-bit payload
  function automatic logic [17:0] pack_word(input logic [1:0] code, input logic [15:0] data);
    return {code, data};
  endfunction

endpackage

// File: rtl/elink_rx_fwft_buf.sv
// elink_rx_fwft_buf: small first-word-fall-through buffer.
// The head word is visible on dout whenever the buffer is non-empty (zero when
// empty). A push onto a full buffer is only accepted if a pop happens in the
// same cycle; otherwise it is silently ignored and the caller flags overflow.
module elink_rx_fwft_buf #(
  parameter int DEPTH = 4,
  parameter int W     = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [DEPTH-1:0] wr_sel;
  logic do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_reg[rd_ptr_reg];

  // One-hot decode of the write slot
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
    assign wr_sel[gi] = (wr_ptr_reg == AW'(gi));
  end

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && wr_sel[i]) mem_reg[i] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/elink_rx_packer.sv
// elink_rx_packer: packs 10-bit e-link bytes into 18-bit RX FIFO words,
// tracks SOP/EOP framing, counts framing errors and buffers a few words
// against FIFO back-pressure.
// Optional build macro ELINK_RX_TIMEOUT_EN: closes a packet that has seen no
// input for TIMEOUT_CYC cycles (counted as a framing error).
module elink_rx_packer
  import elink_rx_pkg::*;
#(
  parameter int BUF_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  din,
  input  logic        din_rdy,
  output logic [17:0] dout,
  output logic        dout_wr_en,
  input  logic        full,
  input  logic        fifoFLUSH,
  output logic        ovf,
  output logic [7:0]  err_cnt
);

  rx_state_e   state_reg, state_next;
  logic [7:0]  held_reg, held_next;
  logic        ovf_reg;
  logic [7:0]  err_cnt_reg;
  logic        push, err_inc;
  logic [17:0] push_word;
  logic        buf_push, buf_pop, buf_empty, buf_full;
  logic [1:0]  in_code;
  logic [7:0]  in_byte;
  logic        timeout_hit;

  assign in_code = din[9:8];
  assign in_byte = din[7:0];

`ifdef ELINK_RX_TIMEOUT_EN
  logic [15:0] idle_cnt_reg;

  // Fires on the TIMEOUT_CYC-th consecutive input-free cycle inside a packet
  assign timeout_hit = (state_reg != IDLE) && !din_rdy &&
                       (idle_cnt_reg == 16'(TIMEOUT_CYC - 1));

  // Idle counter: runs only inside a packet, restarts on any input or state change
  always_ff @(posedge clk) begin
    if (rst || fifoFLUSH) begin
      idle_cnt_reg <= '0;
    end else if (state_reg == IDLE || din_rdy || state_next != state_reg) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_reg + 16'd1;
    end
  end
`else
  logic unused_timeout_cyc;
  assign timeout_hit        = 1'b0;
  assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
`endif

  // Framing decisions: next state, held byte, word to push, error event
  always_comb begin
    state_next = state_reg;
    held_next  = held_reg;
    push       = 1'b0;
    push_word  = '0;
    err_inc    = 1'b0;
    if (din_rdy) begin
      case (state_reg)
        IDLE: begin
          if (in_code == CODE_SOP) begin
            push       = 1'b1;
            push_word  = pack_word(OCODE_SOP, 16'h0000);
            state_next = EVEN;
          end else if (in_code != CODE_COMMA) begin
            err_inc = 1'b1;
          end
        end
        EVEN: begin
          if (in_code == CODE_DATA) begin
            held_next  = in_byte;
            state_next = ODD;
          end else if (in_code == CODE_EOP) begin
            push       = 1'b1;
            push_word  = pack_word(OCODE_EOP, 16'h0000);
            state_next = IDLE;
          end else if (in_code == CODE_SOP) begin
            // Restart inside an open packet: keep the new SOP, count the error
            push      = 1'b1;
            push_word = pack_word(OCODE_SOP, 16'h0000);
            err_inc   = 1'b1;
          end
        end
        ODD: begin
          if (in_code == CODE_DATA) begin
            push       = 1'b1;
            push_word  = pack_word(OCODE_DATA, {held_reg, in_byte});
            state_next = EVEN;
          end else if (in_code == CODE_EOP) begin
            push       = 1'b1;
            push_word  = pack_word(OCODE_LAST1, {held_reg, 8'h00});
            state_next = IDLE;
          end else if (in_code == CODE_SOP) begin
            // Only one push per cycle: the held byte wins, the SOP word is lost
            push       = 1'b1;
            push_word  = pack_word(OCODE_LAST1, {held_reg, 8'h00});
            err_inc    = 1'b1;
            state_next = EVEN;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (timeout_hit) begin
      push       = 1'b1;
      push_word  = (state_reg == ODD) ? pack_word(OCODE_LAST1, {held_reg, 8'h00})
                                      : pack_word(OCODE_EOP, 16'h0000);
      err_inc    = 1'b1;
      state_next = IDLE;
    end
  end

  // Flush overrides everything, including a simultaneous input word
  assign dout_wr_en = !buf_empty && !full && !fifoFLUSH;
  assign buf_pop    = dout_wr_en;
  assign buf_push   = push && !fifoFLUSH;

  // Framing state, held byte, overflow flag and error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      held_reg    <= '0;
      ovf_reg     <= 1'b0;
      err_cnt_reg <= '0;
    end else if (fifoFLUSH) begin
      state_reg <= IDLE;
      held_reg  <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      held_reg  <= held_next;
      if (push && buf_full && !buf_pop) ovf_reg <= 1'b1;
      if (err_inc && err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign ovf     = ovf_reg;
  assign err_cnt = err_cnt_reg;

  elink_rx_fwft_buf #(
    .DEPTH (BUF_DEPTH),
    .W     (18)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifoFLUSH),
    .push      (buf_push),
    .push_data (push_word),
    .pop       (buf_pop),
    .dout      (dout),
    .empty     (buf_empty),
    .full      (buf_full)
  );

endmodule

// File: tb/tb_elink_rx_packer.sv
// tb_elink_rx_packer: directed stimulus for elink_rx_packer with a packet-level
// reference model checked every cycle, plus literal expectations per scenario.
module tb_elink_rx_packer;

  localparam int DEPTH = 4;
  localparam int TO    = 16;

  logic        clk = 1'b0;
  logic        rst, din_rdy, full, fifoFLUSH;
  logic [9:0]  din;
  logic [17:0] dout;
  logic        dout_wr_en, ovf;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  elink_rx_packer #(.BUF_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .din(din), .din_rdy(din_rdy),
    .dout(dout), .dout_wr_en(dout_wr_en), .full(full),
    .fifoFLUSH(fifoFLUSH), .ovf(ovf), .err_cnt(err_cnt)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: open-packet flag, pending byte, output buffer contents
  logic [17:0] m_buf[$];
  bit          m_in_pkt, m_have, m_ovf, m_valid = 0;
  logic [7:0]  m_byte;
  int          m_err, m_idle;
  logic [17:0] got[$];
  logic [17:0] want[$];

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  // Compare DUT against the model mid-cycle, then advance the model by one edge
  always @(negedge clk) begin
    bit          do_pop, have_w;
    logic [17:0] w;
    if (m_valid) begin
      check("dout_wr_en", dout_wr_en, (m_buf.size() > 0) && !full && !fifoFLUSH);
      check("dout", dout, (m_buf.size() > 0) ? m_buf[0] : 18'h0);
      check("ovf", ovf, m_ovf);
      check("err_cnt", err_cnt, m_err);
      if (dout_wr_en) got.push_back(dout);
    end
    have_w = 0;
    w      = '0;
    if (rst) begin
      m_buf.delete(); m_in_pkt = 0; m_have = 0; m_ovf = 0; m_err = 0; m_idle = 0; m_valid = 1;
    end else if (m_valid && fifoFLUSH) begin
      m_buf.delete(); m_in_pkt = 0; m_have = 0; m_ovf = 0; m_idle = 0;
    end else if (m_valid) begin
      do_pop = (m_buf.size() > 0) && !full;
      if (din_rdy) begin
        m_idle = 0;
        case (din[9:8])
          2'b10: begin
            have_w = 1;
            if (!m_in_pkt) begin
              w = 18'h20000; m_in_pkt = 1;
            end else begin
              m_err = sat_inc(m_err);
              w = m_have ? {2'b11, m_byte, 8'h00} : 18'h20000;
              m_have = 0;
            end
          end
          2'b01: begin
            if (!m_in_pkt) m_err = sat_inc(m_err);
            else begin
              have_w = 1;
              w = m_have ? {2'b11, m_byte, 8'h00} : 18'h10000;
              m_in_pkt = 0; m_have = 0;
            end
          end
          2'b00: begin
            if (!m_in_pkt) m_err = sat_inc(m_err);
            else if (m_have) begin
              have_w = 1; w = {2'b00, m_byte, din[7:0]}; m_have = 0;
            end else begin
              m_byte = din[7:0]; m_have = 1;
            end
          end
          default: ;
        endcase
      end else if (m_in_pkt) begin
`ifdef ELINK_RX_TIMEOUT_EN
        m_idle++;
        if (m_idle == TO) begin
          have_w = 1;
          w = m_have ? {2'b11, m_byte, 8'h00} : 18'h10000;
          m_in_pkt = 0; m_have = 0; m_idle = 0;
          m_err = sat_inc(m_err);
        end
`endif
      end
      if (do_pop) void'(m_buf.pop_front());
      if (have_w) begin
        if (m_buf.size() < DEPTH) m_buf.push_back(w);
        else m_ovf = 1;
      end
    end
  end

  task automatic drive(input logic [9:0] w);
    din = w; din_rdy = 1'b1;
    @(posedge clk); #1;
    din_rdy = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_words(input string name);
    check({name, "_count"}, got.size(), want.size());
    for (int i = 0; i < want.size(); i++) begin
      if (i < got.size()) check({name, "_word"}, got[i], want[i]);
    end
  endtask

  initial begin
    din = '0; din_rdy = 0; full = 0; fifoFLUSH = 0; rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("rst_dout", dout, 18'h0);
    check("rst_wr_en", dout_wr_en, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_err", err_cnt, 8'd0);

    // Basic four-byte packet, with one-cycle latency on the SOP word
    got.delete();
    drive(10'h200);
    check("lat_wr_en", dout_wr_en, 1'b1);
    check("lat_dout", dout, 18'h20000);
    drive(10'h011); drive(10'h022); drive(10'h033); drive(10'h044); drive(10'h100);
    idle(3);
    want = '{18'h20000, 18'h01122, 18'h03344, 18'h10000};
    check_words("pkt4");

    // Odd-length packet closes with a single-byte word
    got.delete();
    drive(10'h200); drive(10'h0AB); drive(10'h100);
    idle(3);
    want = '{18'h20000, 18'h3AB00};
    check_words("pkt1");

    // Framing errors: data while idle, SOP while holding a byte
    got.delete();
    drive(10'h055); drive(10'h200); drive(10'h077); drive(10'h200); drive(10'h300);
    drive(10'h100);
    idle(3);
    want = '{18'h20000, 18'h37700, 18'h10000};
    check_words("err");
    check("err_two", err_cnt, 8'd2);

    // Back-pressure: six words into a four-deep buffer
    got.delete();
    full = 1;
    drive(10'h200);
    for (int i = 1; i <= 8; i++) drive(10'(i));
    drive(10'h100);
    idle(2);
    check("ovf_set", ovf, 1'b1);
    want.delete();
    check_words("held_back");
    full = 0;
    idle(8);
    want = '{18'h20000, 18'h00102, 18'h00304, 18'h00506};
    check_words("drain");

    // Flush in ODD together with an input byte
    got.delete();
    full = 1;
    drive(10'h200); drive(10'h012);
    din = 10'h034; din_rdy = 1; fifoFLUSH = 1;
    @(posedge clk); #1;
    din_rdy = 0; fifoFLUSH = 0; full = 0;
    idle(4);
    want.delete();
    check_words("flush_quiet");
    check("flush_ovf", ovf, 1'b0);
    check("flush_err", err_cnt, 8'd2);
    drive(10'h200);
    check("post_flush_sop", dout, 18'h20000);
    drive(10'h100);
    idle(3);
    want = '{18'h20000, 18'h10000};
    check_words("post_flush");

    // Packet left open after one byte
    got.delete();
    drive(10'h200); drive(10'h099);
    idle(20);
`ifdef ELINK_RX_TIMEOUT_EN
    want = '{18'h20000, 18'h39900};
    check_words("timeout");
    check("timeout_err", err_cnt, 8'd3);
`else
    want = '{18'h20000};
    check_words("no_timeout");
    check("no_timeout_err", err_cnt, 8'd2);
    drive(10'h100);
    idle(3);
`endif

    // Reset mid-packet discards buffered words and clears counters
    got.delete();
    full = 1;
    drive(10'h200); drive(10'h0AA);
    rst = 1;
    @(posedge clk); #1;
    rst = 0; full = 0;
    idle(3);
    want.delete();
    check_words("rst_mid");
    check("rst_mid_err", err_cnt, 8'd0);

    // Error counter saturation
    for (int i = 0; i < 260; i++) drive(10'h0AB);
    idle(1);
    check("err_sat", err_cnt, 8'd255);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

endmodule

// File: doc/elink_rx_packer.md
Name: elink_rx_packer

Overview:
Receive-side counterpart of the TX e-link FIFO path. It accepts 10-bit e-link words ({code[1:0], byte[7:0]}) from the e-link deserializer/decoder and packs byte pairs into 18-bit FIFO words ({code[1:0], data[15:0]}). It sits in front of the RX e-link FIFO write port, tracks packet framing and absorbs short downstream back-pressure in a small internal buffer.

Parameters:
BUF_DEPTH, 4, internal output buffer depth in words; power of 2, minimum 2.
TIMEOUT_CYC, 1024, idle cycles inside a packet before a forced close (used only with ELINK_RX_TIMEOUT_EN).

Ports:
clk  in  1  single clock for all logic.
rst  in  1  synchronous, active-high reset.
din  in  10  e-link word. Input codes: 2'b10 SOP, 2'b01 EOP, 2'b00 data byte, 2'b11 comma/idle. The byte field is ignored unless the code is data.
din_rdy  in  1  din valid for this cycle. There is no back-pressure on the input side.
dout  out  18  FIFO word. Output codes: 2'b10 SOP (data 0), 2'b00 two bytes with the first byte in [15:8], 2'b01 EOP (data 0), 2'b11 single last byte in [15:8], [7:0]=0, and also marks end of packet.
dout_wr_en  out  1  write strobe to the RX FIFO.
full  in  1  RX FIFO full.
fifoFLUSH  in  1  synchronous flush.
ovf  out  1  sticky flag: a packed word was dropped because the buffer was full.
err_cnt  out  8  saturating count of framing errors.

Behaviour:
- Reset: state IDLE, held byte cleared, buffer empty, dout=0, dout_wr_en=0, ovf=0, err_cnt=0.
- Framing FSM, evaluated only when din_rdy=1. Comma is ignored in every state.
  - IDLE:
    - SOP: push SOP word, go to EVEN.
    - data or EOP: drop the word, err_cnt+1.
  - EVEN:
    - data: latch the byte, go to ODD.
    - EOP: push EOP word, go to IDLE.
    - SOP: push SOP word, stay in EVEN, err_cnt+1.
  - ODD:
    - data: push {00, held, byte}, go to EVEN.
    - EOP: push {11, held, 8'h00}, go to IDLE.
    - SOP: push {11, held, 8'h00}, err_cnt+1, go to EVEN. The new SOP word is lost and counted in the same error.
- At most one push per cycle.
- Buffer: first-word-fall-through.
  - dout = head word.
  - dout_wr_en = buffer non-empty AND NOT full, combinational from registered state.
  - Pop occurs when dout_wr_en=1.
  - Latency: din_rdy in cycle N gives dout_wr_en in cycle N+1 if the buffer was empty and full=0.
- Push onto a full buffer:
  - If a pop happens in the same cycle, the push succeeds.
  - Otherwise the word is dropped, ovf is set, and the FSM still advances.
- err_cnt saturates at 255. It is cleared only by rst.
- fifoFLUSH=1: buffer emptied, FSM to IDLE, held byte cleared, ovf cleared, dout_wr_en=0 in that cycle.
  - Flush wins over a simultaneous din_rdy; that input is discarded and not counted.
  - err_cnt is kept.
- rst mid-packet: same as the reset values above. No partial words are emitted.

Optional Feature:
ELINK_RX_TIMEOUT_EN.
- Defined: a 16-bit idle counter runs in EVEN/ODD. It clears on any din_rdy (including comma) and on any state change.
  - On reaching TIMEOUT_CYC: from EVEN, push EOP; from ODD, push {11, held, 0}. Then go to IDLE and err_cnt+1.
- Not defined: no counter, no forced close. A packet stays open indefinitely.

Decomposition:
- Package elink_rx_pkg:
  - input code constants CODE_SOP, CODE_EOP, CODE_DATA, CODE_COMMA;
  - output code constants OCODE_SOP, OCODE_DATA, OCODE_EOP, OCODE_LAST1;
  - FSM state enum (IDLE, EVEN, ODD).
- One sub-module, elink_rx_fwft_buf: parameterised FWFT buffer with push, pop, flush, full and empty.

Test Plan:
- Inputs SOP, 0x11, 0x22, 0x33, 0x44, EOP with full=0 → dout sequence 0x20000, 0x01122, 0x03344, 0x10000; each word appears 1 cycle after its completing input.
- Inputs SOP, 0xAB, EOP → 0x20000, then 0x3AB00; no separate EOP word; FSM back in IDLE.
- Data 0x55 while IDLE, then SOP mid-packet in ODD holding 0x77 → err_cnt=2; words 0x20000 then 0x37700 emitted.
- full held high, 6 packed words produced with BUF_DEPTH=4 → first 4 words retained, ovf=1; after full drops, exactly 4 writes in order.
- fifoFLUSH asserted in ODD together with din_rdy → no output, next SOP gives clean 0x20000, ovf=0, err_cnt unchanged.
- With ELINK_RX_TIMEOUT_EN and TIMEOUT_CYC=16: SOP, 0x99, then 16 idle cycles → 0x39900 pushed, err_cnt+1; without the macro, no word is produced.
